// File: rtl/msrv32_wb_unit.sv
// Writeback stage: picks the retiring result (ALU, PC+4, CSR or load), runs the
// data-memory read handshake for loads and drives the register-file write port.
module msrv32_wb_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            wb_valid_in,
    output logic            wb_ready_out,
    input  logic [4:0]      wb_rd_addr_in,
    input  logic            wb_reg_wr_in,
    input  logic [1:0]      wb_src_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [2:0]      load_type_in,
    output logic            dmem_req_out,
    output logic [XLEN-1:0] dmem_addr_out,
    input  logic            dmem_ack_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    output logic            rf_wr_en_out,
    output logic [4:0]      rf_rd_addr_out,
    output logic [XLEN-1:0] rf_rd_out,
    output logic            load_misaligned_out,
    output logic            load_timeout_out
);
    // valid/ready: an operation transfers on a rising edge where wb_valid_in and
    // wb_ready_out are both 1; upstream keeps wb_valid_in and its fields stable until then.
    typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_SAT  = 8'(TIMEOUT_CYCLES);

    function automatic logic [XLEN-1:0] align_load(input logic [2:0]      lt,
                                                   input logic [1:0]      lane,
                                                   input logic [XLEN-1:0] word);
        logic [XLEN-1:0] byte_sh;
        logic [XLEN-1:0] half_sh;
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        case (lt)
            3'b000:  align_load = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  align_load = {24'h000000, byte_sh[7:0]};
            3'b001:  align_load = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  align_load = {16'h0000, half_sh[15:0]};
            default: align_load = word;
        endcase
    endfunction

    // Byte loads never fault; unlisted funct3 codes are handled like LW.
    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] lane);
        case (lt)
            3'b000, 3'b100: is_misaligned = 1'b0;
            3'b001, 3'b101: is_misaligned = lane[0];
            default:        is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      ltype_q, ltype_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_wr_q, reg_wr_d;
    logic            rf_wr_en_q, rf_wr_en_d;
    logic [4:0]      rf_addr_q, rf_addr_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            mis_q, mis_d;
    logic            to_q, to_d;
    logic [XLEN-1:0] src_result;

    always_comb begin
        case (wb_src_in)
            2'b00:   src_result = alu_result_in;
            2'b10:   src_result = pc_plus4_in;
            default: src_result = csr_data_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ltype_d    = ltype_q;
        rd_d       = rd_q;
        reg_wr_d   = reg_wr_q;
        rf_wr_en_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        mis_d      = 1'b0;
        to_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_valid_in) begin
                    if (wb_src_in == 2'b01) begin
                        if (is_misaligned(load_type_in, alu_result_in[1:0])) begin
                            mis_d = 1'b1;
                        end else begin
                            state_d  = MEM_WAIT;
                            cnt_d    = 8'd0;
                            addr_d   = alu_result_in;
                            ltype_d  = load_type_in;
                            rd_d     = wb_rd_addr_in;
                            reg_wr_d = wb_reg_wr_in;
                        end
                    end else if (wb_reg_wr_in && (wb_rd_addr_in != 5'd0)) begin
                        rf_wr_en_d = 1'b1;
                        rf_addr_d  = wb_rd_addr_in;
                        rf_data_d  = src_result;
                    end
                end
            end
            MEM_WAIT: begin
                // An ack on the final counted cycle still completes the load.
                if (dmem_ack_in) begin
                    state_d = IDLE;
                    if (reg_wr_q && (rd_q != 5'd0)) begin
                        rf_wr_en_d = 1'b1;
                        rf_addr_d  = rd_q;
                        rf_data_d  = align_load(ltype_q, addr_q[1:0], dmem_rdata_in);
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = TIMEOUT_SAT;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            ltype_q    <= 3'd0;
            rd_q       <= 5'd0;
            reg_wr_q   <= 1'b0;
            rf_wr_en_q <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_data_q  <= '0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ltype_q    <= ltype_d;
            rd_q       <= rd_d;
            reg_wr_q   <= reg_wr_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
        end
    end

    assign wb_ready_out        = (state_q == IDLE);
    assign dmem_req_out        = (state_q == MEM_WAIT);
    assign dmem_addr_out       = {addr_q[XLEN-1:2], 2'b00};
    assign rf_wr_en_out        = rf_wr_en_q;
    assign rf_rd_addr_out      = rf_addr_q;
    assign rf_rd_out           = rf_data_q;
    assign load_misaligned_out = mis_q;
    assign load_timeout_out    = to_q;

endmodule

// File: tb/tb_msrv32_wb_unit.sv
// Bench for msrv32_wb_unit: directed test-plan scenarios with literal results,
// then random traffic, all checked every cycle against a behavioural model.
module tb_msrv32_wb_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [4:0]  rd_in = 5'd0;
    logic        reg_wr = 1'b0;
    logic [1:0]  src = 2'd0;
    logic [31:0] alu = 32'd0;
    logic [31:0] pc4 = 32'd0;
    logic [31:0] csr = 32'd0;
    logic [2:0]  lt = 3'd0;
    logic        req;
    logic [31:0] daddr;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mis;
    logic        tmo;

    int tests = 0;
    int fails = 0;

    msrv32_wb_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .wb_valid_in(valid),
        .wb_ready_out(ready),
        .wb_rd_addr_in(rd_in),
        .wb_reg_wr_in(reg_wr),
        .wb_src_in(src),
        .alu_result_in(alu),
        .pc_plus4_in(pc4),
        .csr_data_in(csr),
        .load_type_in(lt),
        .dmem_req_out(req),
        .dmem_addr_out(daddr),
        .dmem_ack_in(ack),
        .dmem_rdata_in(rdata),
        .rf_wr_en_out(wr_en),
        .rf_rd_addr_out(wr_addr),
        .rf_rd_out(wr_data),
        .load_misaligned_out(mis),
        .load_timeout_out(tmo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] load_value(input logic [2:0] t, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (t)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic bad_align(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd0 || t == 3'd4) return 1'b0;
        if (t == 3'd1 || t == 3'd5) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    logic        m_busy = 1'b0;
    int          m_waited = 0;
    logic [2:0]  m_lt = 3'd0;
    logic [31:0] m_a = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic        m_wr = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_req = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    logic        exp_wr = 1'b0;
    logic [4:0]  exp_wr_addr = 5'd0;
    logic [31:0] exp_wr_data = 32'd0;
    logic        exp_mis = 1'b0;
    logic        exp_to = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; exp_ready = 1'b1; exp_req = 1'b0; exp_addr = 32'd0;
            exp_wr = 1'b0; exp_wr_addr = 5'd0; exp_wr_data = 32'd0;
            exp_mis = 1'b0; exp_to = 1'b0;
        end else begin
            exp_wr = 1'b0; exp_mis = 1'b0; exp_to = 1'b0;
            if (!m_busy) begin
                if (valid) begin
                    if (src == 2'd1) begin
                        if (bad_align(lt, alu)) exp_mis = 1'b1;
                        else begin
                            m_busy = 1'b1; m_waited = 0; m_lt = lt; m_a = alu;
                            m_rd = rd_in; m_wr = reg_wr;
                            exp_addr = alu - (alu % 4);
                        end
                    end else if (reg_wr && rd_in != 0) begin
                        exp_wr = 1'b1;
                        exp_wr_addr = rd_in;
                        exp_wr_data = (src == 2'd0) ? alu : (src == 2'd2) ? pc4 : csr;
                    end
                end
            end else if (ack) begin
                m_busy = 1'b0;
                if (m_wr && m_rd != 0) begin
                    exp_wr = 1'b1; exp_wr_addr = m_rd;
                    exp_wr_data = load_value(m_lt, m_a, rdata);
                end
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_busy = 1'b0;
                    exp_to = 1'b1;
                end
            end
            exp_ready = !m_busy;
            exp_req = m_busy;
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    logic [31:0] exp_q[$];
    int          obs_req = 0;
    int          obs_mis = 0;
    int          obs_to = 0;
    logic [31:0] obs_addr = 32'd0;

    always @(negedge clk) begin
        check("ready", 32'(ready), 32'(exp_ready));
        check("dmem_req", 32'(req), 32'(exp_req));
        if (exp_req) check("dmem_addr", daddr, exp_addr);
        check("rf_wr_en", 32'(wr_en), 32'(exp_wr));
        check("rf_rd_addr", 32'(wr_addr), 32'(exp_wr_addr));
        check("rf_rd", wr_data, exp_wr_data);
        check("misaligned", 32'(mis), 32'(exp_mis));
        check("timeout", 32'(tmo), 32'(exp_to));
        if (wr_en) exp_q.push_back(wr_data);
        if (req) begin obs_req++; obs_addr = daddr; end
        if (mis) obs_mis++;
        if (tmo) obs_to++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_req = 0; obs_mis = 0; obs_to = 0;
    endtask

    task automatic issue(input logic [1:0] s, input logic [2:0] t, input logic [4:0] r,
                         input logic w, input logic [31:0] v);
        valid = 1'b1; src = s; lt = t; rd_in = r; reg_wr = w;
        alu = v; pc4 = v; csr = v;
        step();
        valid = 1'b0;
    endtask

    // ack arrives in the n-th request cycle; n == 0 means it never arrives
    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] r,
                           input logic [31:0] d, input int n);
        issue(2'd1, t, r, 1'b1, a);
        if (n > 0) begin
            repeat (n - 1) step();
            ack = 1'b1; rdata = d;
            step();
            ack = 1'b0; rdata = 32'd0;
        end
    endtask

    task automatic settle();
        repeat (3) step();
    endtask

    function automatic logic [31:0] first_wr();
        return (exp_q.size() > 0) ? exp_q[0] : 32'hxxxxxxxx;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset req", 32'(req), 32'd0);
        check("reset wr_en", 32'(wr_en), 32'd0);

        // ALU then JAL back-to-back
        clear_obs();
        valid = 1'b1; src = 2'd0; rd_in = 5'd5; reg_wr = 1'b1; alu = 32'h12345678;
        step();
        src = 2'd2; rd_in = 5'd1; pc4 = 32'h104;
        step();
        valid = 1'b0;
        settle();
        check("b2b count", 32'(exp_q.size()), 32'd2);
        check("alu data", first_wr(), 32'h12345678);
        if (exp_q.size() > 1) check("jal data", exp_q[1], 32'h104);

        clear_obs();
        do_load(3'd0, 32'h1003, 5'd7, 32'h80FFFF7F, 3);
        settle();
        check("lb req cycles", 32'(obs_req), 32'd3);
        check("lb addr", obs_addr, 32'h1000);
        check("lb data", first_wr(), 32'hFFFFFF80);

        clear_obs();
        do_load(3'd4, 32'h1003, 5'd7, 32'h80FFFF7F, 3);
        settle();
        check("lbu data", first_wr(), 32'h00000080);

        clear_obs();
        do_load(3'd1, 32'h2002, 5'd8, 32'h80011234, 1);
        settle();
        check("lh data", first_wr(), 32'hFFFF8001);

        clear_obs();
        do_load(3'd5, 32'h2000, 5'd8, 32'h80011234, 2);
        settle();
        check("lhu data", first_wr(), 32'h00001234);

        clear_obs();
        issue(2'd1, 3'd2, 5'd8, 1'b1, 32'h2001);
        settle();
        check("misaligned pulses", 32'(obs_mis), 32'd1);
        check("misaligned req", 32'(obs_req), 32'd0);
        check("misaligned writes", 32'(exp_q.size()), 32'd0);

        clear_obs();
        do_load(3'd2, 32'h3000, 5'd0, 32'hCAFEF00D, 1);
        settle();
        check("rd0 req", 32'(obs_req), 32'd1);
        check("rd0 writes", 32'(exp_q.size()), 32'd0);
        check("rd0 ready", 32'(ready), 32'd1);

        clear_obs();
        do_load(3'd2, 32'h3000, 5'd6, 32'd0, 0);
        repeat (6) step();
        ack = 1'b1; rdata = 32'h11111111;
        step();
        ack = 1'b0;
        settle();
        check("timeout req cycles", 32'(obs_req), 32'd4);
        check("timeout pulses", 32'(obs_to), 32'd1);
        check("timeout writes", 32'(exp_q.size()), 32'd0);

        clear_obs();
        do_load(3'd2, 32'h4000, 5'd9, 32'hDEADBEEF, TO);
        settle();
        check("ack at limit pulses", 32'(obs_to), 32'd0);
        check("ack at limit data", first_wr(), 32'hDEADBEEF);

        // reset in the middle of a memory wait
        issue(2'd1, 3'd2, 5'd3, 1'b1, 32'h3000);
        step();
        #1 rst = 1'b1;
        #1;
        clear_obs();
        check("rst mid req", 32'(req), 32'd0);
        check("rst mid ready", 32'(ready), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) step();
        check("rst no write", 32'(exp_q.size()), 32'd0);
        check("rst no fault", 32'(obs_mis + obs_to), 32'd0);
        issue(2'd0, 3'd0, 5'd4, 1'b1, 32'h55AA);
        settle();
        check("post rst alu", first_wr(), 32'h55AA);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            valid  = 1'($urandom_range(0, 1));
            src    = 2'($urandom_range(0, 3));
            lt     = 3'($urandom_range(0, 7));
            rd_in  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reg_wr = ($urandom_range(0, 7) != 0);
            alu    = $urandom;
            pc4    = $urandom;
            csr    = $urandom;
            ack    = ($urandom_range(0, 3) == 0);
            rdata  = $urandom;
            step();
        end
        valid = 1'b0; ack = 1'b0;
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
